pedal_sampler: RTL and testbench

PEDAL_SAMPLER -- requirements
Module: pedal_sampler

---
 rtl/pedal_pkg.sv | 23 ++
 rtl/tick_divider.sv | 27 ++
 rtl/pedal_sampler.sv | 146 ++++++++++++++
 tb/tb_pedal_sampler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal sampler: FSM encoding, limits and
// the elaboration-time scaling constant.
package pedal_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StScale  = 2'd2,
    StUpdate = 2'd3
  } state_e;

  localparam int unsigned PCT_MAX     = 100;
  localparam int unsigned FAULT_LIMIT = 3;
  localparam int unsigned PROD_W      = 28;

  // ceil(100 * 2^16 / span), so the >>16 in the datapath replaces a divide.
  function automatic int unsigned calc_k(input int unsigned raw_min, input int unsigned raw_max);
    int unsigned span;
    span = raw_max - raw_min;
    return (PCT_MAX * 65536 + span - 1) / span;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period counter; wrap is high during the last cycle of each period.
module tick_divider #(
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] Last = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign wrap = (cnt_q == Last);

endmodule

// File: rtl/pedal_sampler.sv
// Periodically requests an ADC conversion, scales the raw code to 0..100 %
// and publishes it with a one-cycle tick; repeated ADC timeouts latch a fault.
module pedal_sampler
  import pedal_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned ADC_TIMEOUT = 1000,
  parameter int unsigned RAW_MIN     = 400,
  parameter int unsigned RAW_MAX     = 3600
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic        tick_10hz,
  output logic [7:0]  pedal_buffer,
  output logic        adc_fault
);

  localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
  localparam int unsigned K      = calc_k(RAW_MIN, RAW_MAX);
  localparam int unsigned WaitW  = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;

  localparam logic [WaitW-1:0] WaitLast  = WaitW'(ADC_TIMEOUT - 1);
  localparam logic [11:0]      RawMinC   = 12'(RAW_MIN);
  localparam logic [11:0]      RawMaxC   = 12'(RAW_MAX);
  localparam logic [11:0]      PctMaxC   = 12'(PCT_MAX);
  localparam logic [1:0]       FaultLimC = 2'(FAULT_LIMIT);

  logic start;

  tick_divider #(
    .PERIOD(PERIOD)
  ) u_tick_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .wrap (start)
  );

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [11:0]      raw_q, raw_d;
  logic [7:0]       pct_q, pct_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic             fault_q, fault_d;
  logic             tick_q, tick_d;
  logic [7:0]       pb_q, pb_d;

  logic [11:0]       clamped;
  logic [PROD_W-1:0] product;
  logic [11:0]       pct_full;
  logic [7:0]        pct_calc;

  always_comb begin
    clamped = raw_q;
    if (raw_q < RawMinC) begin
      clamped = RawMinC;
    end else if (raw_q > RawMaxC) begin
      clamped = RawMaxC;
    end
    product  = PROD_W'(clamped - RawMinC) * PROD_W'(K);
    pct_full = product[PROD_W-1:16];
    pct_calc = (pct_full > PctMaxC) ? 8'(PCT_MAX) : pct_full[7:0];
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    raw_d     = raw_q;
    pct_d     = pct_q;
    timeout_d = timeout_q;
    tcnt_d    = tcnt_q;
    fault_d   = fault_q;
    tick_d    = 1'b0;
    pb_d      = pb_q;
    unique case (state_q)
      StIdle: begin
        wait_d = '0;
        if (start) state_d = StReq;
      end
      StReq: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (adc_ack) begin
          raw_d     = adc_data;
          timeout_d = 1'b0;
          tcnt_d    = '0;
          state_d   = StScale;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StUpdate;
          if (tcnt_q != FaultLimC) tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == FaultLimC - 2'd1) fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StScale: begin
        pct_d   = pct_calc;
        state_d = StUpdate;
      end
      StUpdate: begin
        tick_d = 1'b1;
        if (fault_q) begin
          pb_d = '0;
        end else if (!timeout_q) begin
          pb_d = pct_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      raw_q     <= '0;
      pct_q     <= '0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
      fault_q   <= 1'b0;
      tick_q    <= 1'b0;
      pb_q      <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      raw_q     <= raw_d;
      pct_q     <= pct_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
      fault_q   <= fault_d;
      tick_q    <= tick_d;
      pb_q      <= pb_d;
    end
  end

  assign adc_req      = (state_q == StReq);
  assign tick_10hz    = tick_q;
  assign pedal_buffer = pb_q;
  assign adc_fault    = fault_q;

endmodule

// File: tb/tb_pedal_sampler.sv
// Self-checking bench for pedal_sampler: directed vector table, reset-in-REQ
// sequence, then randomized conversions checked against a behavioural model.
module tb_pedal_sampler;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 20;
  localparam int K_TB    = 2048;

  logic        clk;
  logic        rst_n;
  logic        adc_req;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic        tick_10hz;
  logic [7:0]  pedal_buffer;
  logic        adc_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_req_cyc = -1;

  typedef struct {
    int delay;  // REQ cycles before ack; -1 means no ack at all
    int raw;
    int pb;
    int fault;
  } vec_t;

  vec_t vecs[21];

  pedal_sampler #(
    .CLK_HZ     (1000),
    .TICK_HZ    (10),
    .ADC_TIMEOUT(20),
    .RAW_MIN    (400),
    .RAW_MAX    (3600)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_req     (adc_req),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .tick_10hz   (tick_10hz),
    .pedal_buffer(pedal_buffer),
    .adc_fault   (adc_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic int model_scale(input int raw);
    int c;
    int p;
    c = (raw < 400) ? 400 : ((raw > 3600) ? 3600 : raw);
    p = ((c - 400) * K_TB) / 65536;
    return (p > 100) ? 100 : p;
  endfunction

  // One full conversion: wait for the request, answer (or not), then check the tick.
  task automatic run_conv(input int delay, input int raw, input int exp_pb, input int exp_fault);
    int n;
    int req_cycles;
    int lat;
    n = 0;
    while (adc_req !== 1'b1 && n < 300) begin
      adc_ack  = 1'($urandom);
      adc_data = 12'($urandom);
      @(negedge clk);
      n++;
    end
    adc_ack = 1'b0;
    if (adc_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_wait no adc_req within %0d cycles", n);
      return;
    end
    if (last_req_cyc >= 0) check("req_period", cyc - last_req_cyc, PERIOD);
    last_req_cyc = cyc;
    req_cycles = 0;
    while (adc_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      adc_ack  = (delay >= 0 && req_cycles == delay + 1);
      adc_data = adc_ack ? 12'(raw) : 12'($urandom);
      @(negedge clk);
    end
    adc_ack = 1'b0;
    check("req_cycles", req_cycles, (delay >= 0) ? delay + 1 : TIMEOUT);
    lat = 0;
    while (tick_10hz !== 1'b1 && lat < 10) begin
      adc_ack  = 1'($urandom);
      adc_data = 12'($urandom);
      @(negedge clk);
      lat++;
    end
    adc_ack = 1'b0;
    check("tick_latency", lat, (delay >= 0) ? 2 : 1);
    check("pedal_buffer", int'(pedal_buffer), exp_pb);
    check("adc_fault", int'(adc_fault), exp_fault);
    @(negedge clk);
    check("tick_width", int'(tick_10hz), 0);
  endtask

  // Hold reset with a live ack, check cleared outputs, then time the first request.
  task automatic reset_seq();
    int n;
    int saw_tick;
    @(negedge clk);
    rst_n    = 1'b0;
    adc_ack  = 1'b1;
    adc_data = 12'd2000;
    saw_tick = 0;
    repeat (3) begin
      @(negedge clk);
      if (tick_10hz) saw_tick = 1;
    end
    check("rst_adc_req", int'(adc_req), 0);
    check("rst_tick", int'(tick_10hz), 0);
    check("rst_pedal_buffer", int'(pedal_buffer), 0);
    check("rst_adc_fault", int'(adc_fault), 0);
    rst_n   = 1'b1;
    adc_ack = 1'b0;
    n = 0;
    while (adc_req !== 1'b1 && n < 300) begin
      adc_ack  = 1'($urandom);
      adc_data = 12'($urandom);
      @(negedge clk);
      n++;
      if (tick_10hz) saw_tick = 1;
    end
    adc_ack = 1'b0;
    check("first_req_after_release", n, PERIOD);
    check("no_tick_around_reset", saw_tick, 0);
    last_req_cyc = -1;
  endtask

  initial begin
    int mt;
    int mf;
    int mpb;
    int n;
    int d;
    int r;

    vecs[0]  = '{2, 2000, 50, 0};
    vecs[1]  = '{0, 3600, 100, 0};
    vecs[2]  = '{5, 4095, 100, 0};
    vecs[3]  = '{7, 100, 0, 0};
    vecs[4]  = '{1, 400, 0, 0};
    vecs[5]  = '{3, 1200, 25, 0};
    vecs[6]  = '{19, 2800, 75, 0};
    vecs[7]  = '{-1, 0, 75, 0};
    vecs[8]  = '{-1, 0, 75, 0};
    vecs[9]  = '{4, 3000, 81, 0};
    vecs[10] = '{-1, 0, 81, 0};
    vecs[11] = '{-1, 0, 81, 0};
    vecs[12] = '{19, 1000, 18, 0};
    vecs[13] = '{-1, 0, 18, 0};
    vecs[14] = '{-1, 0, 18, 0};
    vecs[15] = '{19, 500, 3, 0};
    vecs[16] = '{-1, 0, 3, 0};
    vecs[17] = '{-1, 0, 3, 0};
    vecs[18] = '{-1, 0, 0, 1};
    vecs[19] = '{-1, 0, 0, 1};
    vecs[20] = '{2, 2000, 0, 1};

    rst_n    = 1'b0;
    adc_ack  = 1'b0;
    adc_data = '0;
    reset_seq();

    for (int i = 0; i < 21; i++) begin
      run_conv(vecs[i].delay, vecs[i].raw, vecs[i].pb, vecs[i].fault);
    end

    // Reset while a request is outstanding, with ack arriving during reset.
    n = 0;
    while (adc_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("req_before_reset", int'(adc_req), 1);
    reset_seq();
    run_conv(2, 2000, 50, 0);

    mt  = 0;
    mf  = 0;
    mpb = 50;
    for (int i = 0; i < 30; i++) begin
      d = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 19));
      r = int'($urandom_range(0, 4095));
      if (d >= 0) begin
        mt  = 0;
        mpb = mf ? 0 : model_scale(r);
      end else begin
        mt = (mt < 3) ? mt + 1 : 3;
        if (mt == 3) mf = 1;
        if (mf) mpb = 0;
      end
      run_conv(d, r, mpb, mf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
